// File: rtl/sram_controller_pkg.sv
// Shared types and default constants for the SRAM memory-stage controller.
package sram_ctrl_pkg;

    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned DEF_WAIT_CYCLES = 2;
    localparam int unsigned DEF_SRAM_ADDR_W = 18;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned HALF_W          = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        HALF_LO = 1'b0,
        HALF_HI = 1'b1
    } half_sel_t;

    // Pick the 16-bit half of a word that goes out in the given phase.
    function automatic logic [HALF_W-1:0] half_of(input logic [DATA_W-1:0] word,
                                                  input half_sel_t         sel);
        return (sel == HALF_HI) ? word[DATA_W-1:HALF_W] : word[HALF_W-1:0];
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Pipeline-side request bundle plus SRAM pin bundle of the memory stage.
interface sram_controller_if
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W
) ();

    logic                   MEM_W_EN;
    logic                   MEM_R_EN;
    logic [DATA_W-1:0]      address;
    logic [DATA_W-1:0]      writeData;
    logic [DATA_W-1:0]      readData;
    logic                   ready;
    logic [SRAM_ADDR_W-1:0] SRAM_ADDR;
    logic                   SRAM_WE_N;
    logic [HALF_W-1:0]      SRAM_DQ_OUT;
    logic                   SRAM_DQ_OE;
    logic [HALF_W-1:0]      SRAM_DQ_IN;

    // Pipeline and pad environment side.
    modport master (
        output MEM_W_EN, MEM_R_EN, address, writeData, SRAM_DQ_IN,
        input  readData, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OUT, SRAM_DQ_OE
    );

    // Controller side.
    modport slave (
        input  MEM_W_EN, MEM_R_EN, address, writeData, SRAM_DQ_IN,
        output readData, ready, SRAM_ADDR, SRAM_WE_N, SRAM_DQ_OUT, SRAM_DQ_OE
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Wait-state counter: counts 0..WAIT_CYCLES-1 while enabled, wraps on terminal count.
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc_c
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    assign o_tc_c = i_en && (r_count == LAST);

    // Count up during a phase; restart on clear or at the last wait cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear || o_tc_c) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_controller.sv
// Memory-stage controller: one 32-bit access as two wait-stated 16-bit SRAM accesses.
module sram_controller
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned SRAM_ADDR_W = DEF_SRAM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus
);

    localparam int unsigned WORD_W = SRAM_ADDR_W - 1;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [DATA_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_is_wr;
    logic [DATA_W-1:0]      r_read_data;
    logic [SRAM_ADDR_W-1:0] r_sram_addr;
    logic                   r_we_n;
    logic                   r_oe;
    logic [HALF_W-1:0]      r_dq_out;

    logic                   w_req;
    logic [DATA_W-1:0]      w_src_addr;
    logic [DATA_W-1:0]      w_src_data;
    logic                   w_src_wr;
    logic [DATA_W-1:0]      w_offset;
    logic [WORD_W-1:0]      w_word;
    logic                   w_latch;
    logic                   w_cnt_clear;
    logic                   w_cnt_en;
    logic                   w_tc;
    logic                   w_cap_lo;
    logic                   w_cap_hi;
    half_sel_t              w_half;
    logic [SRAM_ADDR_W-1:0] w_sram_addr;
    logic                   w_we_n;
    logic                   w_oe;
    logic [HALF_W-1:0]      w_dq_out;

    assign w_req = bus.MEM_W_EN | bus.MEM_R_EN;

    // In IDLE the pins are set up from the live request; afterwards from latched copies.
    assign w_src_addr = (r_state == IDLE) ? bus.address   : r_addr;
    assign w_src_data = (r_state == IDLE) ? bus.writeData : r_wdata;
    assign w_src_wr   = (r_state == IDLE) ? bus.MEM_W_EN  : r_is_wr;

    // Byte address to SRAM word index; addresses below the base simply wrap.
    assign w_offset = w_src_addr - DATA_W'(BASE_ADDR);
    assign w_word   = WORD_W'(w_offset >> 2);

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_tc_c  (w_tc)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the pin values for the state being entered.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_cnt_clear  = 1'b0;
        w_cnt_en     = 1'b0;
        w_cap_lo     = 1'b0;
        w_cap_hi     = 1'b0;
        w_half       = HALF_LO;
        w_sram_addr  = '0;
        w_we_n       = 1'b1;
        w_oe         = 1'b0;
        w_dq_out     = '0;

        case (r_state)
            IDLE: begin
                w_cnt_clear = 1'b1;
                if (w_req) begin
                    w_latch      = 1'b1;
                    w_next_state = LOW;
                end
            end
            LOW: begin
                w_cnt_en = 1'b1;
                if (w_tc) begin
                    w_cap_lo     = 1'b1;
                    w_next_state = HIGH;
                end
            end
            HIGH: begin
                w_cnt_en = 1'b1;
                if (w_tc) begin
                    w_cap_hi     = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_cnt_clear  = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase

        if (w_next_state == LOW || w_next_state == HIGH) begin
            w_half      = (w_next_state == HIGH) ? HALF_HI : HALF_LO;
            w_sram_addr = {w_word, w_half};
            if (w_src_wr) begin
                w_we_n   = 1'b0;
                w_oe     = 1'b1;
                w_dq_out = half_of(w_src_data, w_half);
            end
        end
    end

    // Request latch, registered SRAM pins and half-word read capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_wr     <= 1'b0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_we_n      <= 1'b1;
            r_oe        <= 1'b0;
            r_dq_out    <= '0;
        end else begin
            if (w_latch) begin
                r_addr  <= bus.address;
                r_wdata <= bus.writeData;
                r_is_wr <= bus.MEM_W_EN;
            end
            if (w_cap_lo && !r_is_wr) begin
                r_read_data[HALF_W-1:0] <= bus.SRAM_DQ_IN;
            end
            if (w_cap_hi && !r_is_wr) begin
                r_read_data[DATA_W-1:HALF_W] <= bus.SRAM_DQ_IN;
            end
            r_sram_addr <= w_sram_addr;
            r_we_n      <= w_we_n;
            r_oe        <= w_oe;
            r_dq_out    <= w_dq_out;
        end
    end

    assign bus.ready       = ((r_state == IDLE) && !w_req) || (r_state == DONE);
    assign bus.readData    = r_read_data;
    assign bus.SRAM_ADDR   = r_sram_addr;
    assign bus.SRAM_WE_N   = r_we_n;
    assign bus.SRAM_DQ_OE  = r_oe;
    assign bus.SRAM_DQ_OUT = r_dq_out;

endmodule
